divider_xlen: RTL
=================

Name: divider_xlen

Overview:
- Parametrised successor of the rv32im multicycle divider for the kianv harris core.
- Same valid/ready handshake and DIV/DIVU/REM/REMU semantics.
- Generalised to XLEN 32 or 64, with RV64 W-variants (DIVW/DIVUW/REMW/REMUW).
- Retires 1 or 2 quotient bits per cycle, with CLZ early-exit and a power-of-two fast path.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RADIX_LOG2, 1, quotient bits retired per CALC cycle; 1 = radix-2, 2 = radix-4 (two chained restoring steps).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- divident  in  XLEN  dividend operand.
- divisor  in  XLEN  divisor operand.
- DIVop  in  `DIV_OP_WIDTH  operation (`DIV_OP_DIV/DIVU/REM/REMU).
- word_op  in  1  W-variant select; must be 0 when XLEN=32.
- valid  in  1  request; held high until ready.
- ready  out  1  one-cycle completion pulse.
- divOrRemRslt  out  XLEN  quotient for DIV/DIVU, remainder for REM/REMU.
- div_by_zero_err  out  1  combinational; high when the effective input divisor is 0.
- Interface: reset resetn, synchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - ready=0, state=IDLE.
  - All latched operands and results = 0, so divOrRemRslt=0.
  - Reset in any state aborts the operation; no ready pulse is produced.
- Operand preparation:
  - When word_op=1, operands are the low 32 bits, sign-extended (DIV/REM) or zero-extended (DIVU/REMU) to XLEN.
  - Signed ops use magnitudes |a|, |b|.
- States (one-hot): IDLE, FAST, CALC, FIXUP.
- IDLE:
  - Accept when valid=1 and ready=0 (cycle T); latch operands, op and word_op.
  - Compute n = XLEN - clz(|a|), rounded up to a multiple of RADIX_LOG2.
  - Clear quotient and remainder.
  - Next state: FIXUP if divisor==0 or n==0; else FAST if |b| is a power of two; else CALC.
- FAST (one cycle):
  - q = |a| >> ctz(|b|), r = |a| & (|b|-1); go to FIXUP.
- CALC:
  - Each cycle performs RADIX_LOG2 restoring steps, MSB-first from bit index n-1.
  - Bits are selected by mux from latched |a|; no preload shift.
  - Remainder subtract is XLEN+1 bits wide; a negative result keeps the remainder and shifts 0 into q, otherwise 1.
  - After n/RADIX_LOG2 cycles go to FIXUP.
- FIXUP:
  - Divisor 0: q = all-ones, r = effective dividend.
  - Otherwise, for signed ops: negate q if the operand signs differ; negate r if the dividend is negative.
  - The overflow case MIN/-1 naturally yields q = MIN, r = 0.
  - word_op: sign-extend result bit 31 to XLEN.
  - Assert ready for exactly one cycle and return to IDLE.
- Latency (ready high at):
  - Zero or div-by-zero: T+2.
  - Power-of-two divisor: T+3.
  - CALC: T+2+n/RADIX_LOG2.
- Handshake rules:
  - valid seen outside IDLE, or in the cycle ready=1, is ignored (no back-to-back accept).
  - divOrRemRslt holds its value until the next acceptance.

Optional Feature:
- Macro: DIVIDER_RESULT_CACHE_EN.
- With the macro defined:
  - A tag is stored after each completion: effective operands, signedness, word_op, valid bit.
  - Both the final q and the final r are stored.
  - A request whose tag matches goes IDLE -> FIXUP-bypass and returns the cached q or r with ready at T+1. This covers DIV followed by REM on the same operands.
  - Reset clears the valid bit.
- Without the macro: every request computes; no extra registers.

Decomposition:
- Shared package / riscv_defines.vh holds:
  - DIV_OP codes and `DIV_OP_WIDTH.
  - State bit indices.
  - clz/ctz functions, parametrised by XLEN.
- One sub-module: div_restoring_step.
  - Combinational step: remainder, incoming bit, divisor -> next remainder, quotient bit.
  - Instantiated RADIX_LOG2 times and chained.

Test Plan:
- XLEN=32, R=1: DIVU 100/7 -> result 14, ready at T+9; REMU same operands -> 2.
- XLEN=32: REM -7%2 -> 0xFFFFFFFF (-1); DIV -7/2 -> 0xFFFFFFFD (-3); both via FAST, ready at T+3.
- XLEN=32: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, div_by_zero_err=1, ready at T+2.
- XLEN=64, R=2: DIVW a=0x0000_0001_8000_0000, b=3 -> 0xFFFFFFFF_D5555556. DIVU 100/7 -> 14, ready at T+6.
- Reset driven low mid-CALC -> no ready pulse, divOrRemRslt=0. A following DIVU 9/3 -> 3 completes normally.
- DIVIDER_RESULT_CACHE_EN: DIV 1000/7 then REM 1000/7 -> 142, then 6 with ready at T+1. A changed divisor misses and recomputes.

Source files
------------

// File: rtl/divider_xlen_pkg.sv
// Shared definitions for divider_xlen: operation codes, one-hot state encoding
// and leading/trailing zero counters usable at any XLEN up to 64.
package divider_xlen_pkg;

    localparam int DIV_OP_WIDTH = 2;

    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

    localparam int ST_IDLE_BIT  = 0;
    localparam int ST_FAST_BIT  = 1;
    localparam int ST_CALC_BIT  = 2;
    localparam int ST_FIXUP_BIT = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'(4'd1 << ST_IDLE_BIT),
        ST_FAST  = 4'(4'd1 << ST_FAST_BIT),
        ST_CALC  = 4'(4'd1 << ST_CALC_BIT),
        ST_FIXUP = 4'(4'd1 << ST_FIXUP_BIT)
    } div_state_e;

    // Operand is right-aligned in v; only the low xlen bits are considered.
    function automatic logic [6:0] clz_xlen(input logic [63:0] v, input int xlen);
        clz_xlen = 7'(xlen);
        for (int i = 0; i < 64; i++) begin
            if (i < xlen && v[i]) begin
                clz_xlen = 7'(xlen - 1 - i);
            end
        end
    endfunction

    function automatic logic [6:0] ctz_xlen(input logic [63:0] v, input int xlen);
        ctz_xlen = 7'(xlen);
        for (int i = 63; i >= 0; i--) begin
            if (i < xlen && v[i]) begin
                ctz_xlen = 7'(i);
            end
        end
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the remainder on a negative result.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // rem_i < divisor_i always holds, so XLEN+1 bits suffice to expose the borrow.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (diff_s[XLEN]) begin
            rem_o = shifted_s[XLEN-1:0];
            q_o   = 1'b0;
        end else begin
            rem_o = diff_s[XLEN-1:0];
            q_o   = 1'b1;
        end
    end

endmodule

// File: rtl/divider_xlen.sv
// Multicycle XLEN divider (DIV/DIVU/REM/REMU plus RV64 W-forms) with CLZ early
// exit and power-of-two fast path. Optional result cache: DIVIDER_RESULT_CACHE_EN.
module divider_xlen
    import divider_xlen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_LOG2 = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [XLEN-1:0]         divident,
    input  logic [XLEN-1:0]         divisor,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic                    word_op,
    input  logic                    valid,
    output logic                    ready,
    output logic [XLEN-1:0]         divOrRemRslt,
    output logic                    div_by_zero_err
);

    localparam int IDXW = $clog2(XLEN);

    div_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] a_abs_q, a_abs_d;
    logic [XLEN-1:0] b_abs_q, b_abs_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            is_rem_q, is_rem_d;
    logic            word_q, word_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic            in_signed_s, in_rem_s;
    logic [XLEN-1:0] eff_a_s, eff_b_s, abs_a_s, abs_b_s;
    logic            in_a_neg_s, in_b_neg_s;
    logic [6:0]      n_raw_s, n_s, ctz_s;
    logic            pow2_s, accept_s;
    logic [XLEN-1:0] q_base_s, r_mag_s, r_base_s, q_fin_s, r_fin_s;
    logic            cache_hit_s;
    logic [XLEN-1:0] hit_res_s;

    logic [XLEN-1:0]       chain_rem_s [RADIX_LOG2+1];
    logic [RADIX_LOG2-1:0] qbits_s;

    // Decode the request and form effective operands and their magnitudes.
    always_comb begin
        case (DIVop)
            DIV_OP_DIV:  begin in_signed_s = 1'b1; in_rem_s = 1'b0; end
            DIV_OP_DIVU: begin in_signed_s = 1'b0; in_rem_s = 1'b0; end
            DIV_OP_REM:  begin in_signed_s = 1'b1; in_rem_s = 1'b1; end
            DIV_OP_REMU: begin in_signed_s = 1'b0; in_rem_s = 1'b1; end
            default:     begin in_signed_s = 1'b0; in_rem_s = 1'b0; end
        endcase
        if (word_op) begin
            eff_a_s = in_signed_s ? XLEN'($signed(divident[31:0])) : XLEN'(divident[31:0]);
            eff_b_s = in_signed_s ? XLEN'($signed(divisor[31:0]))  : XLEN'(divisor[31:0]);
        end else begin
            eff_a_s = divident;
            eff_b_s = divisor;
        end
        in_a_neg_s = in_signed_s & eff_a_s[XLEN-1];
        in_b_neg_s = in_signed_s & eff_b_s[XLEN-1];
        abs_a_s    = in_a_neg_s ? -eff_a_s : eff_a_s;
        abs_b_s    = in_b_neg_s ? -eff_b_s : eff_b_s;
        n_raw_s    = 7'(XLEN) - clz_xlen(64'(abs_a_s), XLEN);
        if (RADIX_LOG2 == 2) begin
            n_s = (n_raw_s + 7'd1) & 7'b111_1110;
        end else begin
            n_s = n_raw_s;
        end
        pow2_s   = (abs_b_s & (abs_b_s - XLEN'(1'b1))) == {XLEN{1'b0}};
        accept_s = (state_q == ST_IDLE) && valid && !ready_q;
        ctz_s    = ctz_xlen(64'(b_abs_q), XLEN);
    end

    assign div_by_zero_err = (eff_b_s == {XLEN{1'b0}});

    // Final sign correction and W-form extension of quotient and remainder.
    always_comb begin
        if (div0_q) begin
            q_base_s = {XLEN{1'b1}};
            r_mag_s  = a_abs_q;
        end else begin
            q_base_s = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
            r_mag_s  = rem_q;
        end
        r_base_s = a_neg_q ? -r_mag_s : r_mag_s;
        if (word_q) begin
            q_fin_s = XLEN'($signed(q_base_s[31:0]));
            r_fin_s = XLEN'($signed(r_base_s[31:0]));
        end else begin
            q_fin_s = q_base_s;
            r_fin_s = r_base_s;
        end
    end

    assign chain_rem_s[0] = rem_q;

    for (genvar k = 0; k < RADIX_LOG2; k++) begin : g_step
        logic [IDXW-1:0] bit_idx_s;
        assign bit_idx_s = idx_q - IDXW'(k);
        div_restoring_step #(.XLEN(XLEN)) u_step (
            .rem_i     (chain_rem_s[k]),
            .bit_i     (a_abs_q[bit_idx_s]),
            .divisor_i (b_abs_q),
            .rem_o     (chain_rem_s[k+1]),
            .q_o       (qbits_s[RADIX_LOG2-1-k])
        );
    end

    // Next-state and datapath update for the one-hot controller.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        res_d    = res_q;
        a_abs_d  = a_abs_q;
        b_abs_d  = b_abs_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        is_rem_d = is_rem_q;
        word_d   = word_q;
        div0_d   = div0_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_abs_d  = abs_a_s;
                    b_abs_d  = abs_b_s;
                    a_neg_d  = in_a_neg_s;
                    b_neg_d  = in_b_neg_s;
                    is_rem_d = in_rem_s;
                    word_d   = word_op;
                    div0_d   = div_by_zero_err;
                    quo_d    = {XLEN{1'b0}};
                    rem_d    = {XLEN{1'b0}};
                    idx_d    = IDXW'(n_s - 7'd1);
                    if (cache_hit_s) begin
                        res_d   = hit_res_s;
                        ready_d = 1'b1;
                    end else if (div_by_zero_err || n_s == 7'd0) begin
                        state_d = ST_FIXUP;
                    end else if (pow2_s) begin
                        state_d = ST_FAST;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAST: begin
                quo_d   = a_abs_q >> ctz_s;
                rem_d   = a_abs_q & (b_abs_q - XLEN'(1'b1));
                state_d = ST_FIXUP;
            end
            ST_CALC: begin
                quo_d = {quo_q[XLEN-1-RADIX_LOG2:0], qbits_s};
                rem_d = chain_rem_s[RADIX_LOG2];
                if (idx_q == IDXW'(RADIX_LOG2 - 1)) begin
                    state_d = ST_FIXUP;
                end else begin
                    idx_d = idx_q - IDXW'(RADIX_LOG2);
                end
            end
            ST_FIXUP: begin
                res_d   = is_rem_q ? r_fin_s : q_fin_s;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            res_q    <= {XLEN{1'b0}};
            a_abs_q  <= {XLEN{1'b0}};
            b_abs_q  <= {XLEN{1'b0}};
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            div0_q   <= 1'b0;
            quo_q    <= {XLEN{1'b0}};
            rem_q    <= {XLEN{1'b0}};
            idx_q    <= {IDXW{1'b0}};
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            res_q    <= res_d;
            a_abs_q  <= a_abs_d;
            b_abs_q  <= b_abs_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            is_rem_q <= is_rem_d;
            word_q   <= word_d;
            div0_q   <= div0_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
        end
    end

`ifdef DIVIDER_RESULT_CACHE_EN
    logic [XLEN-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic            tag_sgn_q, tag_sgn_d, tag_word_q, tag_word_d;
    logic            cache_vld_q, cache_vld_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

    // Hit when the effective request matches the last completed operation.
    always_comb begin
        cache_hit_s = cache_vld_q && (tag_a_q == eff_a_s) && (tag_b_q == eff_b_s)
                      && (tag_sgn_q == in_signed_s) && (tag_word_q == word_op);
        hit_res_s   = in_rem_s ? cache_rem_q : cache_quo_q;
    end

    // Tag is captured at a missed accept and only becomes valid on completion.
    always_comb begin
        tag_a_d     = tag_a_q;
        tag_b_d     = tag_b_q;
        tag_sgn_d   = tag_sgn_q;
        tag_word_d  = tag_word_q;
        cache_vld_d = cache_vld_q;
        cache_quo_d = cache_quo_q;
        cache_rem_d = cache_rem_q;
        if (accept_s && !cache_hit_s) begin
            tag_a_d     = eff_a_s;
            tag_b_d     = eff_b_s;
            tag_sgn_d   = in_signed_s;
            tag_word_d  = word_op;
            cache_vld_d = 1'b0;
        end else if (state_q == ST_FIXUP) begin
            cache_vld_d = 1'b1;
            cache_quo_d = q_fin_s;
            cache_rem_d = r_fin_s;
        end else begin
            cache_vld_d = cache_vld_q;
        end
    end

    // Result cache registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_a_q     <= {XLEN{1'b0}};
            tag_b_q     <= {XLEN{1'b0}};
            tag_sgn_q   <= 1'b0;
            tag_word_q  <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_quo_q <= {XLEN{1'b0}};
            cache_rem_q <= {XLEN{1'b0}};
        end else begin
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            tag_sgn_q   <= tag_sgn_d;
            tag_word_q  <= tag_word_d;
            cache_vld_q <= cache_vld_d;
            cache_quo_q <= cache_quo_d;
            cache_rem_q <= cache_rem_d;
        end
    end
`else
    assign cache_hit_s = 1'b0;
    assign hit_res_s   = {XLEN{1'b0}};
`endif

    assign ready        = ready_q;
    assign divOrRemRslt = res_q;

endmodule
